// File: rtl/imem_program_loader_if.sv
// Byte-stream ingress and IMEM write port of the program loader.
// The loader connects through the slave modport (it consumes the byte
// stream and produces the IMEM writes); a stream source/IMEM model uses master.
interface imem_program_loader_if #(
  parameter int ADDR_WIDTH = 8
) ();

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/imem_program_loader.sv
// imem_program_loader
// Receives a length-prefixed byte image (LEN_LO, LEN_HI, then 4*N data bytes,
// LSB first), assembles little-endian 32-bit words and writes them to
// consecutive IMEM word addresses starting at 0. The core is held in reset
// until the image is fully committed.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte (XOR of all data bytes) before the image is accepted.
module imem_program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  imem_program_loader_if.slave bus,
  output logic                 cpu_reset_hold,
  output logic                 done,
  output logic                 error
);

  // Largest accepted word count; one more would overrun the IMEM.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  state_t                state_r;
  logic [15:0]           len_r;
  logic [ADDR_WIDTH-1:0] word_idx_r;
  logic [1:0]            byte_cnt_r;
  logic [23:0]           word_buf_r;

  logic                  transfer_s;
  logic [15:0]           len_s;
  logic [16:0]           len_ext_s;
  logic                  last_word_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_r;

  // Running checksum update: XOR of every data byte seen so far.
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data_byte);
    return acc ^ data_byte;
  endfunction
`endif

  // Handshake decode, full word count as it completes, and last-word detect.
  always_comb begin
    transfer_s  = 1'b0;
    len_s       = 16'd0;
    len_ext_s   = 17'd0;
    last_word_s = 1'b0;
    if (bus.in_valid && bus.in_ready) begin
      transfer_s = 1'b1;
    end else begin
      transfer_s = 1'b0;
    end
    len_s       = {bus.in_data, len_r[7:0]};
    len_ext_s   = {1'b0, len_s};
    last_word_s = ({{(17-ADDR_WIDTH){1'b0}}, word_idx_r} == ({1'b0, len_r} - 17'd1));
  end

  // Loader FSM: stream parsing, word assembly, IMEM write strobe and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      len_r          <= 16'd0;
      word_idx_r     <= '0;
      byte_cnt_r     <= 2'd0;
      word_buf_r     <= 24'd0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
      cpu_reset_hold <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r         <= 8'd0;
`endif
    end else begin
      // The write strobe is a single-cycle pulse; address/data hold otherwise.
      bus.imem_we <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r      <= ST_LEN0;
          bus.in_ready <= 1'b1;
        end

        ST_LEN0: begin
          if (transfer_s) begin
            len_r[7:0] <= bus.in_data;
            state_r    <= ST_LEN1;
          end
        end

        ST_LEN1: begin
          if (transfer_s) begin
            len_r <= len_s;
            if (len_s == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              // Empty image still carries a checksum byte (expected 8'h00).
              state_r <= ST_CHK;
`else
              state_r      <= ST_DONE;
              done         <= 1'b1;
              bus.in_ready <= 1'b0;
`endif
            end else if (len_ext_s > MAX_WORDS) begin
              state_r      <= ST_ERROR;
              error        <= 1'b1;
              bus.in_ready <= 1'b0;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (transfer_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r <= xor_fold(csum_r, bus.in_data);
`endif
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
              2'd0: word_buf_r[7:0]   <= bus.in_data;
              2'd1: word_buf_r[15:8]  <= bus.in_data;
              2'd2: word_buf_r[23:16] <= bus.in_data;
              2'd3: begin
                // Fourth byte completes the word; it is written next cycle
                // while the stream keeps flowing.
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= word_idx_r;
                bus.imem_wdata <= {bus.in_data, word_buf_r};
                word_idx_r     <= word_idx_r + ADDR_WIDTH'(1'b1);
                if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_r <= ST_CHK;
`else
                  state_r      <= ST_DONE;
                  done         <= 1'b1;
                  bus.in_ready <= 1'b0;
`endif
                end
              end
              default: word_buf_r <= word_buf_r;
            endcase
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (transfer_s) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == csum_r) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
            end else begin
              // Words already written stay in IMEM; the core remains held.
              state_r <= ST_ERROR;
              error   <= 1'b1;
            end
          end
        end
`endif

        ST_DONE, ST_ERROR: begin
          if (start) begin
            state_r        <= ST_LEN0;
            bus.in_ready   <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            cpu_reset_hold <= 1'b1;
            len_r          <= 16'd0;
            word_idx_r     <= '0;
            byte_cnt_r     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r         <= 8'd0;
`endif
          end else begin
            // Core is released only once the image is committed (the cycle
            // after entering DONE, i.e. after the final write pulse).
            cpu_reset_hold <= (state_r == ST_ERROR);
          end
        end

        default: begin
          state_r        <= ST_IDLE;
          bus.in_ready   <= 1'b0;
          cpu_reset_hold <= 1'b1;
          done           <= 1'b0;
          error          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: stimulus tasks push expected
// IMEM writes into a scoreboard queue; a negedge monitor pops and compares.
module tb_imem_program_loader;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_reset_hold;
  logic done;
  logic error;

  imem_program_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .bus            (bus),
    .cpu_reset_hold (cpu_reset_hold),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  int          errors   = 0;
  int          checks   = 0;
  int          xfer_cnt = 0;
  int          wr_cnt   = 0;
  logic [39:0] exp_q[$];
  logic [39:0] mon_exp_w;
  logic [31:0] img [0:255];

  // Count accepted bytes on the edge where the loader samples them.
  always @(posedge clk) begin
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) xfer_cnt++;
  end

  // Scoreboard: every IMEM write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_exp_w = exp_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== mon_exp_w) begin
          errors++;
          $display("FAIL imem_write got addr=%0d data=%h exp addr=%0d data=%h",
                   bus.imem_addr, bus.imem_wdata, mon_exp_w[39:32], mon_exp_w[31:0]);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Drive one byte (called at a negedge); returns at the negedge after transfer.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int gap_n;
    int wait_cyc;
    if (gaps) begin
      gap_n = $urandom_range(0, 3);
      for (int i = 0; i < gap_n; i++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    wait_cyc     = 0;
    while (bus.in_ready !== 1'b1 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout in_ready=%b exp=1", bus.in_ready);
    end else begin
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Send a full image of n words from img[], queueing the expected writes.
  task automatic send_image(input int n, input bit gaps);
    logic [15:0] n16;
    logic [31:0] w;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  x;
    x = 8'h00;
`endif
    n16 = 16'(n);
    send_byte(n16[7:0], gaps);
    send_byte(n16[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      exp_q.push_back({8'(i), w});
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = x ^ w[8*k +: 8];
`endif
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x, gaps);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we got=%b exp=0", bus.imem_we); end
    checks++; if (bus.imem_addr !== 8'd0) begin errors++; $display("FAIL reset_imem_addr got=%0d exp=0", bus.imem_addr); end
    checks++; if (bus.imem_wdata !== 32'd0) begin errors++; $display("FAIL reset_imem_wdata got=%h exp=0", bus.imem_wdata); end
    checks++; if (cpu_reset_hold !== 1'b1) begin errors++; $display("FAIL reset_hold got=%b exp=1", cpu_reset_hold); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL len0_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int wr0;
    wr0    = wr_cnt;
    img[0] = 32'h00000013;
    img[1] = 32'h00100093;
    send_image(2, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", done); end
    checks++; if (cpu_reset_hold !== 1'b1) begin errors++; $display("FAIL basic_hold_at_last got=%b exp=1", cpu_reset_hold); end
`ifndef IMEM_LOADER_CHECKSUM_EN
    checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'd1) begin errors++; $display("FAIL basic_latency we=%b addr=%0d exp we=1 addr=1", bus.imem_we, bus.imem_addr); end
`endif
    @(negedge clk);
    checks++; if (cpu_reset_hold !== 1'b0) begin errors++; $display("FAIL basic_hold_release got=%b exp=0", cpu_reset_hold); end
    checks++; if (done !== 1'b1 || error !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_status done=%b error=%b ready=%b exp 1 0 0", done, error, bus.in_ready); end
    checks++; if (wr_cnt - wr0 !== 2 || exp_q.size() !== 0) begin errors++; $display("FAIL basic_writes got=%0d pending=%0d exp 2 0", wr_cnt - wr0, exp_q.size()); end
  endtask

  task automatic test_zero_len();
    int wr0;
    pulse_start();
    checks++; if (done !== 1'b0 || cpu_reset_hold !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL restart done=%b hold=%b ready=%b exp 0 1 1", done, cpu_reset_hold, bus.in_ready); end
    wr0 = wr_cnt;
    send_image(0, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
    @(negedge clk);
    checks++; if (cpu_reset_hold !== 1'b0) begin errors++; $display("FAIL zero_hold got=%b exp=0", cpu_reset_hold); end
    checks++; if (wr_cnt !== wr0) begin errors++; $display("FAIL zero_writes got=%0d exp=0", wr_cnt - wr0); end
  endtask

  task automatic test_overflow();
    int wr0;
    pulse_start();
    wr0 = wr_cnt;
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ovf_status error=%b done=%b exp 1 0", error, done); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got=%b exp=0", bus.in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (cpu_reset_hold !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL ovf_hold hold=%b error=%b exp 1 1", cpu_reset_hold, error); end
    checks++; if (wr_cnt !== wr0) begin errors++; $display("FAIL ovf_writes got=%0d exp=0", wr_cnt - wr0); end
    pulse_start();
    checks++; if (error !== 1'b0 || bus.in_ready !== 1'b1 || cpu_reset_hold !== 1'b1) begin errors++; $display("FAIL ovf_restart error=%b ready=%b hold=%b exp 0 1 1", error, bus.in_ready, cpu_reset_hold); end
  endtask

  task automatic test_max_len();
    int wr0;
    wr0 = wr_cnt;
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    send_image(256, 1'b0);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL max_status done=%b error=%b exp 1 0", done, error); end
    @(negedge clk);
    checks++; if (wr_cnt - wr0 !== 256 || exp_q.size() !== 0) begin errors++; $display("FAIL max_writes got=%0d pending=%0d exp 256 0", wr_cnt - wr0, exp_q.size()); end
    checks++; if (cpu_reset_hold !== 1'b0) begin errors++; $display("FAIL max_hold got=%b exp=0", cpu_reset_hold); end
  endtask

  task automatic test_gaps();
    int x0;
    int exp_x;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_x = 19;
`else
    exp_x = 18;
`endif
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      x0 = xfer_cnt;
      send_image(4, pass == 1);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL gaps_done pass=%0d got=%b exp=1", pass, done); end
      @(negedge clk);
      checks++; if (xfer_cnt - x0 !== exp_x) begin errors++; $display("FAIL gaps_xfers pass=%0d got=%0d exp=%0d", pass, xfer_cnt - x0, exp_x); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL gaps_pending pass=%0d got=%0d exp=0", pass, exp_q.size()); end
    end
  endtask

  task automatic test_reset_mid_load();
    int wr0;
    logic [31:0] old0;
    logic [31:0] old1;
    old0 = 32'hA1B2C3D4;
    old1 = 32'h55667788;
    pulse_start();
    wr0 = wr_cnt;
    exp_q.push_back({8'd0, old0});
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(old0[8*k +: 8], 1'b0);
    for (int k = 0; k < 2; k++) send_byte(old1[8*k +: 8], 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_addr !== 8'd0 || bus.imem_wdata !== 32'd0) begin errors++; $display("FAIL midrst_outputs addr=%0d data=%h exp 0 0", bus.imem_addr, bus.imem_wdata); end
    checks++; if (cpu_reset_hold !== 1'b1 || bus.in_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_status hold=%b ready=%b done=%b exp 1 0 0", cpu_reset_hold, bus.in_ready, done); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL midrst_first_word pending=%0d exp=0", exp_q.size()); end
    reset = 1'b1;
    @(negedge clk);
    img[0] = 32'h00500537;
    send_image(1, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_reload_done got=%b exp=1", done); end
    @(negedge clk);
    checks++; if (wr_cnt - wr0 !== 2 || exp_q.size() !== 0) begin errors++; $display("FAIL midrst_writes got=%0d pending=%0d exp 2 0", wr_cnt - wr0, exp_q.size()); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    img[0] = 32'h00000013;
    send_image(1, 1'b0);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL csum_good done=%b error=%b exp 1 0", done, error); end
    pulse_start();
    exp_q.push_back({8'd0, 32'h00000013});
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL csum_bad error=%b done=%b exp 1 0", error, done); end
    @(negedge clk);
    checks++; if (cpu_reset_hold !== 1'b1 || exp_q.size() !== 0) begin errors++; $display("FAIL csum_bad_hold hold=%b pending=%0d exp 1 0", cpu_reset_hold, exp_q.size()); end
    pulse_start();
    send_image(1, 1'b0);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL csum_retry done=%b error=%b exp 1 0", done, error); end
  endtask
`endif

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_max_len();
    test_gaps();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
